// File: rtl/alu_half_sequencer_pkg.sv
// ============================================================================
// Module : alu_half_sequencer_pkg
// Brief  : Shared types and helpers for the two-pass ALU half sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_half_sequencer_pkg;

  typedef enum logic [3:0] {
    ALU_OP_AND = 4'd0,
    ALU_OP_OR  = 4'd1,
    ALU_OP_XOR = 4'd2,
    ALU_OP_ADD = 4'd3,
    ALU_OP_SUB = 4'd4,
    ALU_OP_SLL = 4'd5,
    ALU_OP_SRL = 4'd6,
    ALU_OP_SRA = 4'd7,
    ALU_OP_EQ  = 4'd8,
    ALU_OP_LT  = 4'd9,
    ALU_OP_LTU = 4'd10
  } cs_alu_op;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } alu_seq_state_e;

  // Right shifts must see the high half first so its spill feeds the low half.
  function automatic logic is_hi_first(input cs_alu_op op);
    return (op == ALU_OP_SRL) || (op == ALU_OP_SRA);
  endfunction

  function automatic logic is_shift_op(input cs_alu_op op);
    return (op == ALU_OP_SLL) || (op == ALU_OP_SRL) || (op == ALU_OP_SRA);
  endfunction

  function automatic logic is_cmp_op(input cs_alu_op op);
    return (op == ALU_OP_EQ) || (op == ALU_OP_LT) || (op == ALU_OP_LTU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_half_sequencer_splitter.sv
// ============================================================================
// Module : alu_operand_splitter
// Brief  : Selects operand halves and shift amount for each slice pass.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_operand_splitter
  import alu_half_sequencer_pkg::*;
#(
  parameter int HALF_W = 16
) (
  input  cs_alu_op              op,
  input  logic [2*HALF_W-1:0]   a,
  input  logic [2*HALF_W-1:0]   b,
  input  alu_seq_state_e        state,
  output logic                  first_cycle,
  output logic [HALF_W-1:0]     half_a,
  output logic [HALF_W-1:0]     half_b
);

  localparam int SHAMT_W = $clog2(2 * HALF_W);

  logic [HALF_W-1:0]  w_a_lo;
  logic [HALF_W-1:0]  w_a_hi;
  logic [HALF_W-1:0]  w_b_lo;
  logic [HALF_W-1:0]  w_b_hi;
  logic [HALF_W-1:0]  w_a_first;
  logic [HALF_W-1:0]  w_a_second;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_shift;
  logic               w_far;

  assign w_a_lo     = a[HALF_W-1:0];
  assign w_a_hi     = a[2*HALF_W-1:HALF_W];
  assign w_b_lo     = b[HALF_W-1:0];
  assign w_b_hi     = b[2*HALF_W-1:HALF_W];
  assign w_a_first  = is_hi_first(op) ? w_a_hi : w_a_lo;
  assign w_a_second = is_hi_first(op) ? w_a_lo : w_a_hi;
  assign w_shamt    = b[SHAMT_W-1:0];
  assign w_shift    = is_shift_op(op);
  assign w_far      = w_shamt[SHAMT_W-1];

  always_comb begin
    first_cycle = 1'b0;
    half_a      = '0;
    half_b      = '0;
    case (state)
      PASS1: begin
        first_cycle = 1'b1;
        half_a      = w_a_first;
        half_b      = w_shift ? HALF_W'(w_shamt) : w_b_lo;
      end
      PASS2: begin
        if (w_shift && w_far) begin
          // Whole-half shift: restart on the same source half with the residual amount.
          first_cycle = 1'b1;
          half_a      = w_a_first;
          half_b      = HALF_W'(w_shamt[SHAMT_W-2:0]);
        end else if (w_shift) begin
          half_a = w_a_second;
          half_b = HALF_W'(w_shamt);
        end else begin
          half_a = w_a_second;
          half_b = w_b_hi;
        end
      end
      default: begin
        first_cycle = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_half_sequencer.sv
// ============================================================================
// Module : alu_half_sequencer
// Brief  : Runs a 32-bit operation as two passes over the 16-bit ALU slice.
//          Optional macro CMP_EARLY_EXIT_EN: EQ finishes after PASS1 on a
//          low-half mismatch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_half_sequencer
  import alu_half_sequencer_pkg::*;
#(
  parameter int HALF_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  cs_alu_op            in_op,
  input  logic                in_cmp_flip,
  input  logic [2*HALF_W-1:0] in_a,
  input  logic [2*HALF_W-1:0] in_b,
  output logic                alu_first_cycle,
  output cs_alu_op            alu_op,
  output logic                alu_cmp_flip,
  output logic [HALF_W-1:0]   alu_a,
  output logic [HALF_W-1:0]   alu_b,
  input  logic [HALF_W-1:0]   alu_result,
  input  logic                alu_cmp_result,
  input  logic                alu_cmp_valid,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*HALF_W-1:0] out_result,
  output logic                out_cmp
);

  localparam int XLEN = 2 * HALF_W;

  alu_seq_state_e    r_state;
  alu_seq_state_e    w_next;
  cs_alu_op          r_op;
  logic              r_cmp_flip;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_result;
  logic              r_cmp;
  logic              w_accept;
  logic              w_in_pass;
  logic              w_split_first;
  logic [HALF_W-1:0] w_split_a;
  logic [HALF_W-1:0] w_split_b;

  assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_in_pass = (r_state == PASS1) || (r_state == PASS2);

  alu_operand_splitter #(
    .HALF_W (HALF_W)
  ) u_splitter (
    .op          (r_op),
    .a           (r_a),
    .b           (r_b),
    .state       (r_state),
    .first_cycle (w_split_first),
    .half_a      (w_split_a),
    .half_b      (w_split_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    alu_first_cycle = 1'b0;
    alu_op          = ALU_OP_AND;
    alu_cmp_flip    = 1'b0;
    alu_a           = '0;
    alu_b           = '0;
    out_valid       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = PASS1;
      end
      PASS1: begin
`ifdef CMP_EARLY_EXIT_EN
        if ((r_op == ALU_OP_EQ) && alu_cmp_valid) w_next = DONE;
        else                                      w_next = PASS2;
`else
        w_next = PASS2;
`endif
      end
      PASS2: begin
        w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = in_valid ? PASS1 : IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    // The slice only sees real operands while a pass is in flight.
    if (w_in_pass) begin
      alu_first_cycle = w_split_first;
      alu_op          = r_op;
      alu_cmp_flip    = r_cmp_flip;
      alu_a           = w_split_a;
      alu_b           = w_split_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= ALU_OP_AND;
      r_cmp_flip <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_cmp      <= 1'b0;
    end else if (w_accept) begin
      r_op       <= in_op;
      r_cmp_flip <= in_cmp_flip;
      r_a        <= in_a;
      r_b        <= in_b;
      r_result   <= '0;
      r_cmp      <= 1'b0;
    end else if (w_in_pass) begin
      // PASS1 fills the half it read first; PASS2 fills the other one.
      if ((r_state == PASS1) == is_hi_first(r_op)) begin
        r_result[XLEN-1:HALF_W] <= alu_result;
      end else begin
        r_result[HALF_W-1:0] <= alu_result;
      end
      if (alu_cmp_valid) r_cmp <= alu_cmp_result;
    end
  end

  always_comb begin
    out_result = '0;
    out_cmp    = 1'b0;
    if (out_valid) begin
      if (is_cmp_op(r_op)) begin
        out_result = {{(XLEN-1){1'b0}}, r_cmp};
        out_cmp    = r_cmp;
      end else begin
        out_result = r_result;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_half_sequencer.sv
// ============================================================================
// Module : tb_alu_half_sequencer
// Brief  : Directed bench for alu_half_sequencer with a behavioural slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_half_sequencer;
  import alu_half_sequencer_pkg::*;

`ifdef CMP_EARLY_EXIT_EN
  localparam int EQ_MISS_LAT = 2;
`else
  localparam int EQ_MISS_LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  cs_alu_op    in_op = ALU_OP_AND;
  logic        in_cmp_flip = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        alu_first_cycle;
  cs_alu_op    alu_op;
  logic        alu_cmp_flip;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;
  logic        alu_cmp_result;
  logic        alu_cmp_valid;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_cmp;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_half_sequencer #(.HALF_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_op           (in_op),
    .in_cmp_flip     (in_cmp_flip),
    .in_a            (in_a),
    .in_b            (in_b),
    .alu_first_cycle (alu_first_cycle),
    .alu_op          (alu_op),
    .alu_cmp_flip    (alu_cmp_flip),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_result      (alu_result),
    .alu_cmp_result  (alu_cmp_result),
    .alu_cmp_valid   (alu_cmp_valid),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_result      (out_result),
    .out_cmp         (out_cmp)
  );

  // Behavioural 16-bit two-pass slice: carry, shift spill and low-half compare state.
  logic        s_carry, s_eq_lo, s_ltu_lo;
  logic [15:0] s_spill;
  logic        n_carry, n_eq_lo, n_ltu_lo;
  logic [15:0] n_spill;
  logic [16:0] sum;
  logic [31:0] tmp;

  always_comb begin
    alu_result     = '0;
    alu_cmp_result = 1'b0;
    alu_cmp_valid  = 1'b0;
    n_carry        = s_carry;
    n_spill        = s_spill;
    n_eq_lo        = s_eq_lo;
    n_ltu_lo       = s_ltu_lo;
    sum            = '0;
    tmp            = '0;
    case (alu_op)
      ALU_OP_AND: alu_result = alu_a & alu_b;
      ALU_OP_OR:  alu_result = alu_a | alu_b;
      ALU_OP_XOR: alu_result = alu_a ^ alu_b;
      ALU_OP_ADD: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b} + {16'b0, (alu_first_cycle ? 1'b0 : s_carry)};
        alu_result = sum[15:0];
        n_carry    = sum[16];
      end
      ALU_OP_SUB: begin
        sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {16'b0, (alu_first_cycle ? 1'b1 : s_carry)};
        alu_result = sum[15:0];
        n_carry    = sum[16];
      end
      ALU_OP_SLL: begin
        tmp = {16'b0, alu_a} << alu_b[4:0];
        alu_result = tmp[15:0] | (alu_first_cycle ? 16'h0 : s_spill);
        n_spill    = tmp[31:16];
      end
      ALU_OP_SRL, ALU_OP_SRA: begin
        if (alu_op == ALU_OP_SRA && alu_first_cycle) tmp = $signed({alu_a, 16'h0}) >>> alu_b[4:0];
        else                                          tmp = {alu_a, 16'h0} >> alu_b[4:0];
        alu_result = tmp[31:16] | (alu_first_cycle ? 16'h0 : s_spill);
        n_spill    = tmp[15:0];
      end
      ALU_OP_EQ, ALU_OP_LT, ALU_OP_LTU: begin
        if (alu_first_cycle) begin
          n_eq_lo  = (alu_a == alu_b);
          n_ltu_lo = (alu_a < alu_b);
          if (alu_op == ALU_OP_EQ && alu_a != alu_b) begin
            alu_cmp_valid  = 1'b1;
            alu_cmp_result = alu_cmp_flip;
          end
        end else begin
          alu_cmp_valid = 1'b1;
          if (alu_op == ALU_OP_EQ)
            alu_cmp_result = alu_cmp_flip ^ (s_eq_lo && alu_a == alu_b);
          else if (alu_op == ALU_OP_LTU)
            alu_cmp_result = alu_cmp_flip ^ ((alu_a < alu_b) || (alu_a == alu_b && s_ltu_lo));
          else
            alu_cmp_result = alu_cmp_flip ^ (($signed(alu_a) < $signed(alu_b)) || (alu_a == alu_b && s_ltu_lo));
        end
      end
      default: alu_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_carry  <= 1'b0;
      s_spill  <= '0;
      s_eq_lo  <= 1'b0;
      s_ltu_lo <= 1'b0;
    end else if (alu_first_cycle) begin
      s_carry  <= n_carry;
      s_spill  <= n_spill;
      s_eq_lo  <= n_eq_lo;
      s_ltu_lo <= n_ltu_lo;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input cs_alu_op op, input logic [31:0] a,
                        input logic [31:0] b, input logic flip, input logic [31:0] exp_res,
                        input logic exp_cmp, input int exp_lat);
    int w;
    int lat;
    in_op       = op;
    in_a        = a;
    in_b        = b;
    in_cmp_flip = flip;
    in_valid    = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    chk({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, out_result, exp_res);
    chk({tag, "_cmp"}, {31'b0, out_cmp}, {31'b0, exp_cmp});
    step();
  endtask

  initial begin
    // Reset state
    step();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_alu_a", {16'b0, alu_a}, 32'd0);
    chk("rst_alu_fc", {31'b0, alu_first_cycle}, 32'd0);
    chk("rst_alu_op", {28'b0, alu_op}, 32'd0);
    rst_n = 1'b1;
    step();

    run_op("add_carry", ALU_OP_ADD, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 3);
    run_op("sub_borrow", ALU_OP_SUB, 32'h00010000, 32'h00000001, 1'b0, 32'h0000FFFF, 1'b0, 3);
    run_op("xor", ALU_OP_XOR, 32'hF0F01234, 32'h0FF0FFFF, 1'b0, 32'hFF00EDCB, 1'b0, 3);
    run_op("sra20", ALU_OP_SRA, 32'h80000000, 32'd20, 1'b0, 32'hFFFFF800, 1'b0, 3);
    run_op("srl20", ALU_OP_SRL, 32'h80000000, 32'd20, 1'b0, 32'h00000800, 1'b0, 3);
    run_op("sll17", ALU_OP_SLL, 32'h00000001, 32'd17, 1'b0, 32'h00020000, 1'b0, 3);
    run_op("srl8", ALU_OP_SRL, 32'h12345678, 32'd8, 1'b0, 32'h00123456, 1'b0, 3);
    run_op("sll4", ALU_OP_SLL, 32'h00018001, 32'd4, 1'b0, 32'h00180010, 1'b0, 3);
    run_op("lt", ALU_OP_LT, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'd1, 1'b1, 3);
    run_op("ltu", ALU_OP_LTU, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'd0, 1'b0, 3);
    run_op("geu", ALU_OP_LTU, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'd1, 1'b1, 3);
    run_op("eq_miss", ALU_OP_EQ, 32'h12345678, 32'h12345679, 1'b0, 32'd0, 1'b0, EQ_MISS_LAT);
    run_op("ne_miss", ALU_OP_EQ, 32'h12345678, 32'h12345679, 1'b1, 32'd1, 1'b1, EQ_MISS_LAT);
    run_op("eq_hit", ALU_OP_EQ, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'd1, 1'b1, 3);

    // Backpressure then back-to-back acceptance
    out_ready = 1'b0;
    in_op = ALU_OP_ADD; in_a = 32'd5; in_b = 32'd7; in_cmp_flip = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) step();
    in_a = 32'd100; in_b = 32'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_result", out_result, 32'd12);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("b2b_valid_low", {31'b0, out_valid}, 32'd0);
    chk("b2b_fc", {31'b0, alu_first_cycle}, 32'd1);
    chk("b2b_alu_a", {16'b0, alu_a}, 32'h00000064);
    step();
    step();
    chk("b2b_valid", {31'b0, out_valid}, 32'd1);
    chk("b2b_result", out_result, 32'd101);
    step();

    // Reset during PASS2
    in_op = ALU_OP_SUB; in_a = 32'h00010000; in_b = 32'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("p2_alu_a", {16'b0, alu_a}, 32'h00000001);
    chk("p2_fc", {31'b0, alu_first_cycle}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_alu_a", {16'b0, alu_a}, 32'd0);
    chk("arst_alu_op", {28'b0, alu_op}, 32'd0);
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
    end
    run_op("or_after_rst", ALU_OP_OR, 32'h0F0F0000, 32'h000000F0, 1'b0, 32'h0F0F00F0, 1'b0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/alu_half_sequencer.md
Name: alu_half_sequencer

Overview:
Upstream and downstream wrapper for the 16-bit two-pass ALU slice (alu_sbm).
- Accepts one 32-bit operation per valid/ready handshake.
- Splits the operands into two 16-bit passes and drives the slice's first_cycle, op and cmp_flip.
- Reassembles the two 16-bit results into a 32-bit result, plus the compare outcome.
- Presents the result on a valid/ready output toward writeback and branch resolution.

Parameters:
HALF_W, 16, slice datapath width; XLEN = 2*HALF_W (fixed at 32, not overridable).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operation request
- in_ready  out  1  sequencer can accept a request
- in_op  in  cs_alu_op  operation
- in_cmp_flip  in  1  invert compare sense (NE, GE, GEU)
- in_a  in  32  operand A
- in_b  in  32  operand B (shift amount in [4:0])
- alu_first_cycle  out  1  slice pass indicator
- alu_op  out  cs_alu_op  slice operation
- alu_cmp_flip  out  1  slice compare flip
- alu_a  out  16  slice operand A half
- alu_b  out  16  slice operand B half
- alu_result  in  16  slice result half
- alu_cmp_result  in  1  slice compare outcome
- alu_cmp_valid  in  1  slice compare outcome valid
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_result  out  32  assembled result
- out_cmp  out  1  compare outcome (0 for non-compare ops)

Behaviour:
- FSM states: IDLE, PASS1, PASS2, DONE.
  - Reset: IDLE, with all outputs 0 except in_ready=1. Operand and result registers are 0.
  - Reset mid-operation aborts the operation with no output.
- Transitions:
  - IDLE: on in_valid & in_ready, latch op, cmp_flip, a and b, then go to PASS1.
  - PASS1 → PASS2 unconditionally, except the optional early exit.
  - PASS2 → DONE.
  - DONE: on out_ready, go to IDLE. If in_valid is also high in that cycle, latch the new request and go directly to PASS1 (back-to-back).
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Latency: request accepted at edge t; out_valid asserted from cycle t+3 and held until out_ready.
- out_result and out_cmp are stable while out_valid=1.
- Half order:
  - SRL, SRA: high half in PASS1, low half in PASS2.
  - All other ops: low half in PASS1, high half in PASS2. This carries ADD/SUB and places the LT/LTU sign in PASS2.
- Slice drive in PASS1: alu_first_cycle=1, alu_a/alu_b = selected halves, alu_op and alu_cmp_flip = latched values.
- Slice drive in PASS2: alu_first_cycle=0.
- Shifts:
  - alu_b in both passes = {11'b0, shamt[4:0]}; alu_a = the half selected by the order above.
  - When shamt[4]=1, PASS2 re-drives alu_first_cycle=1, alu_b = {12'b0, shamt[3:0]}, and alu_a = the same source half as PASS1 (high for SRL/SRA, low for SLL).
  - The PASS2 result fills the near half; the PASS1 result (0 or sign fill) fills the far half.
- IDLE and DONE drive: alu_op=ALU_OP_AND, alu_a=alu_b=0, alu_first_cycle=0. This prevents slice state updates.
- Result capture: the PASS1 result is stored in its half and the PASS2 result in the other half.
- Compare ops (EQ, LT, LTU):
  - out_result = {31'b0, out_cmp}.
  - out_cmp = alu_cmp_result sampled in the pass where alu_cmp_valid=1; the PASS2 sample is final.
- Non-compare ops: out_cmp=0.
- out_valid=1 & out_ready=0: hold in DONE, in_ready=0, inputs ignored.

Optional Feature:
CMP_EARLY_EXIT_EN
- Defined: for ALU_OP_EQ, if alu_cmp_valid=1 in PASS1 (the low halves differ), capture alu_cmp_result and go PASS1 → DONE. Latency is then 2 cycles.
- Undefined: always two passes; latency is always 3 cycles.

Decomposition:
- cs_alu_op is already in typedefs.
- Add to typedefs:
  - an enum alu_seq_state_e {IDLE, PASS1, PASS2, DONE};
  - a function is_hi_first(cs_alu_op);
  - a function is_cmp_op(cs_alu_op).
- Sub-module alu_operand_splitter: combinational half and shift-amount selection from latched operands, op and pass.
- The top level holds the FSM, registers and result assembly.
- Integration bench: alu_half_sequencer driving alu_sbm.

Test Plan:
1. ADD a=0x0000FFFF, b=0x00000001 → out_result=0x00010000, out_valid at t+3.
2. SRA a=0x80000000, shamt=20 → 0xFFFFF800. SRL same operands → 0x00000800. SLL a=0x00000001, shamt=17 → 0x00020000.
3. LT a=0xFFFFFFFF, b=0x00000001 → out_cmp=1. LTU same → out_cmp=0. LTU with in_cmp_flip=1 → out_cmp=1.
4. EQ a=0x12345678, b=0x12345679, flip=0 → out_cmp=0. With CMP_EARLY_EXIT_EN → out_valid at t+2.
5. Backpressure: hold out_ready=0 for 5 cycles → result stable, in_ready=0. Then out_ready=1 with in_valid=1 → new op accepted the same cycle.
6. Assert rst_n=0 during PASS2 → outputs zero asynchronously, state IDLE, no out_valid after release.
